// File: rtl/mem_copy_engine.sv
// ============================================================================
//  Module   : mem_copy_engine
//  Summary  : Word-by-word RAM-to-RAM copier, two cycles per word (read/write).
//             COPY_OVERLAP_EN selects memmove-style descending order on overlap.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_copy_engine #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 15,
    parameter int LEN_WIDTH     = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] srcAddr,
    input  logic [ADDRESS_WIDTH-1:0] dstAddr,
    input  logic [LEN_WIDTH-1:0]     len,
    output logic                     busy,
    output logic                     done,
    output logic                     memWEn,
    output logic [ADDRESS_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0]    memDataIn,
    input  logic [DATA_WIDTH-1:0]    memDataOut
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_src;
    logic [ADDRESS_WIDTH-1:0] r_dst;
    logic [LEN_WIDTH-1:0]     r_remain;
    logic [LEN_WIDTH-1:0]     r_offset;
    logic [LEN_WIDTH-1:0]     w_offset_init;
    logic [LEN_WIDTH-1:0]     w_offset_next;
    logic [ADDRESS_WIDTH-1:0] w_off_ext;

`ifdef COPY_OVERLAP_EN
    localparam int CMP_W = (ADDRESS_WIDTH > LEN_WIDTH) ? ADDRESS_WIDTH : LEN_WIDTH;

    logic [ADDRESS_WIDTH-1:0] w_dist;
    logic                     w_desc_in;
    logic                     r_desc;

    // A destination that starts inside the source window must be filled from the top down.
    assign w_dist        = dstAddr - srcAddr;
    assign w_desc_in     = (w_dist != '0) && (CMP_W'(w_dist) < CMP_W'(len));
    assign w_offset_init = w_desc_in ? (len - 1'b1) : '0;
    assign w_offset_next = r_desc ? (r_offset - 1'b1) : (r_offset + 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_desc <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_desc <= w_desc_in;
        end
    end
`else
    assign w_offset_init = '0;
    assign w_offset_next = r_offset + 1'b1;
`endif

    assign w_off_ext = ADDRESS_WIDTH'(r_offset);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = (len != '0) ? S_READ : S_DONE;
            S_READ:  w_next_state = S_WRITE;
            S_WRITE: w_next_state = (r_remain == LEN_WIDTH'(1)) ? S_DONE : S_READ;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_remain <= '0;
            r_offset <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_src    <= srcAddr;
                r_dst    <= dstAddr;
                r_remain <= len;
                r_offset <= w_offset_init;
            end
        end else if (r_state == S_WRITE) begin
            r_remain <= r_remain - 1'b1;
            r_offset <= w_offset_next;
        end
    end

    // Write enable is masked by reset so an abort never lands a write on the reset edge.
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        memWEn    = 1'b0;
        memAddr   = '0;
        memDataIn = '0;
        case (r_state)
            S_READ: begin
                memAddr = r_src + w_off_ext;
            end
            S_WRITE: begin
                memWEn    = ~reset;
                memAddr   = r_dst + w_off_ext;
                memDataIn = memDataOut;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
//  Module   : tb_mem_copy_engine
//  Summary  : Scoreboard bench for mem_copy_engine with a behavioural RAM model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;

    localparam int DW    = 32;
    localparam int AW    = 15;
    localparam int LW    = 12;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int            kind;   // 0 read, 1 write, 2 done
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] srcAddr;
    logic [AW-1:0] dstAddr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          memWEn;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memDataIn;
    logic [DW-1:0] memDataOut;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    logic [DW-1:0] ram       [DEPTH];
    bit            vld       [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];
    ev_t           expq[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    mem_copy_engine #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .LEN_WIDTH    (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .srcAddr   (srcAddr),
        .dstAddr   (dstAddr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .memWEn    (memWEn),
        .memAddr   (memAddr),
        .memDataIn (memDataIn),
        .memDataOut(memDataOut)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        return vld[a] ? ram[a] : init_val(a);
    endfunction

    // Synchronous RAM: read data appears the cycle after a read, held across writes.
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
            vld[pl_addr] <= 1'b1;
        end else if (memWEn) begin
            ram[memAddr] <= memDataIn;
            vld[memAddr] <= 1'b1;
        end else begin
            memDataOut <= ram_rd(memAddr);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        model_mem[a] = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic push_ev(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        expq.push_back(e);
    endtask

    // abort_rel >= 0 raises reset during relative cycle abort_rel and issues a second start at rel 2.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                            input bit noise, input int abort_rel);
        int            k;
        int            end_rel;
        int            cnt;
        bit            desc;
        logic [AW-1:0] diff;
        logic [AW-1:0] sa;
        logic [AW-1:0] da;
        logic [DW-1:0] w;
        k    = cyc + 1;
        cnt  = int'(n);
        desc = 1'b0;
        diff = d - s;
`ifdef COPY_OVERLAP_EN
        desc = (diff != '0) && (int'(diff) < cnt);
`endif
        for (int j = 0; j < cnt; j++) begin
            int o;
            o  = desc ? (cnt - 1 - j) : j;
            sa = s + AW'(o);
            da = d + AW'(o);
            if (abort_rel < 0 || 2 * j < abort_rel)
                push_ev(0, sa, '0, k + 2 * j);
            if (abort_rel < 0 || 2 * j + 1 < abort_rel) begin
                w = model_mem[sa];
                push_ev(1, da, w, k + 2 * j + 1);
                model_mem[da] = w;
            end
        end
        if (abort_rel < 0) push_ev(2, '0, '0, k + 2 * cnt);
        end_rel = (abort_rel < 0) ? 2 * cnt : abort_rel;

        srcAddr = s;
        dstAddr = d;
        len     = n;
        start   = 1'b1;
        tick();
        start = 1'b0;
        while (cyc <= k + end_rel) begin
            if (noise) begin
                srcAddr = AW'($urandom);
                dstAddr = AW'($urandom);
                len     = LW'($urandom);
                start   = ($urandom_range(0, 3) == 0);
            end
            if (abort_rel >= 0 && cyc == k + 2) begin
                srcAddr = 15'h0700;
                dstAddr = 15'h0710;
                len     = 12'd3;
                start   = 1'b1;
            end
            if (abort_rel >= 0 && cyc == k + abort_rel) reset = 1'b1;
            tick();
            start = 1'b0;
        end
        start = 1'b0;
        reset = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int            mism;
        logic [AW-1:0] rs;
        logic [AW-1:0] rd;
        reset   = 1'b1;
        start   = 1'b0;
        srcAddr = '0;
        dstAddr = '0;
        len     = '0;
        pl_en   = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = init_val(AW'(a));

        // Monitor: classifies each non-idle cycle and matches it against the scoreboard queue.
        fork
            forever begin
                @(negedge clk);
                if (mon_en && !reset) begin
                    if (!busy) begin
                        checks++;
                        if (done || memWEn || memAddr != '0 || memDataIn != '0) begin
                            errors++;
                            $display("FAIL idle_outputs cyc=%0d got done=%b wen=%b addr=%h din=%h want all zero",
                                     cyc, done, memWEn, memAddr, memDataIn);
                        end
                    end else begin
                        int  kind;
                        ev_t e;
                        kind = memWEn ? 1 : (done ? 2 : 0);
                        checks++;
                        if (expq.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_event cyc=%0d got kind=%0d addr=%h want no activity",
                                     cyc, kind, memAddr);
                        end else begin
                            e = expq.pop_front();
                            if (kind != e.kind || cyc != e.cyc || memAddr != e.addr ||
                                (kind == 1 && memDataIn != e.data) || (kind == 2 && memWEn)) begin
                                errors++;
                                $display("FAIL event cyc=%0d got kind=%0d addr=%h data=%h want kind=%0d addr=%h data=%h cyc=%0d",
                                         cyc, kind, memAddr, memDataIn, e.kind, e.addr, e.data, e.cyc);
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_wen",  64'(memWEn), 64'd0);
        chk("reset_addr", 64'(memAddr), 64'd0);
        chk("reset_din",  64'(memDataIn), 64'd0);
        reset = 1'b0;
        tick();
        mon_en = 1'b1;

        // Basic four-word copy.
        preload(15'h0100, 32'hAAAA_0001);
        preload(15'h0101, 32'hBBBB_0002);
        preload(15'h0102, 32'hCCCC_0003);
        preload(15'h0103, 32'hDDDD_0004);
        run_copy(15'h0100, 15'h0200, 12'd4, 1'b0, -1);
        chk("copy4_w0", 64'(ram_rd(15'h0200)), 64'h0000_0000_AAAA_0001);
        chk("copy4_w1", 64'(ram_rd(15'h0201)), 64'h0000_0000_BBBB_0002);
        chk("copy4_w2", 64'(ram_rd(15'h0202)), 64'h0000_0000_CCCC_0003);
        chk("copy4_w3", 64'(ram_rd(15'h0203)), 64'h0000_0000_DDDD_0004);

        // Zero-length request, with input noise while busy.
        run_copy(15'h0050, 15'h0060, 12'd0, 1'b1, -1);

        // Source address wraps past the top of the address space.
        run_copy(15'h7FFE, 15'h0010, 12'd4, 1'b0, -1);

        // Forward overlap by one word.
        preload(15'h0100, 32'd1);
        preload(15'h0101, 32'd2);
        preload(15'h0102, 32'd3);
        preload(15'h0103, 32'd4);
        run_copy(15'h0100, 15'h0101, 12'd4, 1'b0, -1);
`ifdef COPY_OVERLAP_EN
        chk("overlap_w0", 64'(ram_rd(15'h0101)), 64'd1);
        chk("overlap_w1", 64'(ram_rd(15'h0102)), 64'd2);
        chk("overlap_w2", 64'(ram_rd(15'h0103)), 64'd3);
        chk("overlap_w3", 64'(ram_rd(15'h0104)), 64'd4);
`else
        chk("overlap_w0", 64'(ram_rd(15'h0101)), 64'd1);
        chk("overlap_w1", 64'(ram_rd(15'h0102)), 64'd1);
        chk("overlap_w2", 64'(ram_rd(15'h0103)), 64'd1);
        chk("overlap_w3", 64'(ram_rd(15'h0104)), 64'd1);
`endif

        // Source equals destination.
        run_copy(15'h0500, 15'h0500, 12'd3, 1'b1, -1);

        // Abort mid-transfer with a second start ignored.
        run_copy(15'h0300, 15'h0400, 12'd8, 1'b0, 5);
        chk("abort_w2_untouched", 64'(ram_rd(15'h0402)), 64'(init_val(15'h0402)));

        // Maximum length.
        run_copy(AW'($urandom), AW'($urandom), 12'hFFF, 1'b0, -1);

        // Randomised transfers, many of them overlapping in either direction.
        for (int t = 0; t < 30; t++) begin
            rs = AW'($urandom);
            case ($urandom_range(0, 2))
                0:       rd = rs + AW'($urandom_range(0, 12));
                1:       rd = rs - AW'($urandom_range(0, 12));
                default: rd = AW'($urandom);
            endcase
            run_copy(rs, rd, LW'($urandom_range(0, 16)), 1'b1, -1);
        end

        repeat (3) tick();
        chk("queue_drained", 64'(expq.size()), 64'd0);
        mism = 0;
        for (int a = 0; a < DEPTH; a++)
            if (ram_rd(AW'(a)) !== model_mem[a]) mism++;
        chk("ram_image_mismatches", 64'(mism), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width of the attached RAM.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 15: RAM word-address width; all address arithmetic is modulo 2^ADDRESS_WIDTH.
REQ-003 SHALL have parameter LEN_WIDTH, default 12: width of the word-count operand.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock, shared with the RAM.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  request pulse; sampled only in IDLE.
REQ-008 srcAddr  input  ADDRESS_WIDTH  first source word address; captured on accepted start.
REQ-009 dstAddr  input  ADDRESS_WIDTH  first destination word address; captured on accepted start.
REQ-010 len  input  LEN_WIDTH  words to copy; captured on accepted start; 0 is legal.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 memWEn  output  1  RAM write enable.
REQ-014 memAddr  output  ADDRESS_WIDTH  RAM address.
REQ-015 memDataIn  output  DATA_WIDTH  RAM write data.
REQ-016 memDataOut  input  DATA_WIDTH  RAM read data; valid the cycle after a read cycle (wEn=0), held during write cycles.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-018 IDLE: start=1 at a rising edge SHALL capture srcAddr/dstAddr/len and move to READ if len!=0, else to DONE.
REQ-019 READ: memWEn=0, memAddr=captured src + current offset; next state WRITE.
REQ-020 WRITE: memWEn=1, memAddr=captured dst + same offset, memDataIn=memDataOut; next state READ if words remain, else DONE.
REQ-021 DONE: done=1 for exactly this cycle; next state IDLE.
REQ-022 Throughput SHALL be 2 cycles/word; start sampled at edge k gives done high in cycle k+2*len+1 (k+1 for len=0).
REQ-023 memWEn, memAddr, busy and done SHALL decode only from registered state/counters; no combinational path from start, srcAddr, dstAddr or len.
REQ-024 In IDLE and DONE, memWEn=0, memAddr=0 and memDataIn=0.
REQ-025 start while busy SHALL be ignored and not queued; input changes after capture SHALL not affect the transfer in progress.
REQ-026 Address increment/decrement SHALL wrap modulo 2^ADDRESS_WIDTH (e.g. src 0x7FFF then 0x0000 when ADDRESS_WIDTH=15).
REQ-027 Internal word counter SHALL be LEN_WIDTH bits; len=2^LEN_WIDTH-1 SHALL copy exactly that many words.
REQ-028 srcAddr==dstAddr SHALL perform the full read/write sequence (rewriting identical data) with normal timing.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, busy=0, done=0, memWEn=0, memAddr=0, memDataIn=0 and clear captured operands and counter, taking priority over start.
REQ-030 Reset mid-transfer SHALL abort without a done pulse; words already written are not restored; no write occurs in the cycle after the reset edge.

Configuration
REQ-031 Macro COPY_OVERLAP_EN SHALL select overlap-safe ordering.
REQ-032 With COPY_OVERLAP_EN defined: if ((dst-src) mod 2^ADDRESS_WIDTH) is nonzero and < len, offsets SHALL run len-1 down to 0 (memmove semantics); otherwise ascending 0 to len-1.
REQ-033 Without COPY_OVERLAP_EN: offsets SHALL always ascend 0 to len-1; overlapping forward copies propagate data (documented, not an error); the direction logic SHALL not be synthesised.

Verification
REQ-034 RAM preloaded 0x100..0x103 = A,B,C,D; start src=0x100 dst=0x200 len=4 at edge k -> 0x200..0x203 = A,B,C,D, memWEn high in cycles k+2,4,6,8, done high only in cycle k+9.
REQ-035 start len=0 -> memWEn never asserted, busy high only in cycle k+1, done high in cycle k+1.
REQ-036 src=0x7FFE dst=0x0010 len=4 (ADDRESS_WIDTH=15) -> reads 0x7FFE,0x7FFF,0x0000,0x0001; writes 0x0010..0x0013.
REQ-037 0x100..0x103 = 1,2,3,4, src=0x100 dst=0x101 len=4 -> with COPY_OVERLAP_EN 0x101..0x104 = 1,2,3,4; without it 0x101..0x104 = 1,1,1,1.
REQ-038 start len=8, second start pulse in cycle k+3, reset asserted in cycle k+6 -> second start ignored, IDLE and memWEn=0 from cycle k+7, no done pulse, only words 0..1 written.
